pe2ddr_wr_burst: RTL and testbench

- Executes one DDR write transfer descriptor produced by the pe2ddr configuration stage.
- The descriptor fields are start, st_addr, burst, step and burst_num; one instance serves each DDR port (ddr1, ddr2).
- Generates an AXI4-style write address/data/response sequence of burst_num bursts, each of burst beats, at addresses st_addr + k*step.
- Streams write data from the PE output buffer selected upstream, and returns a single done pulse to the configuration stage.

---
 rtl/pe2ddr_wr_burst_pkg.sv | 32 +++
 rtl/pe2ddr_wr_burst_addr_gen.sv | 102 ++++++++++
 rtl/pe2ddr_wr_burst.sv | 165 ++++++++++++++++
 tb/tb_pe2ddr_wr_burst.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe2ddr_wr_burst_pkg.sv
// Shared types and constants for the pe2ddr write-burst engine.
package pe2ddr_wr_burst_pkg;

  localparam int GP_DDR_ADDR_W = 32;
  localparam int GP_BURST_W    = 8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Write transfer descriptor handed over by the configuration stage
  typedef struct packed {
    logic [GP_DDR_ADDR_W-1:0] st_addr;
    logic [GP_BURST_W-1:0]    burst;
    logic [GP_DDR_ADDR_W-1:0] step;
    logic [GP_BURST_W-1:0]    burst_num;
  } ddr_burst_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  // AXI length field is beats-1; a zero-beat burst never reaches the bus,
  // so it maps to 0 to keep awlen quiet.
  function automatic logic [7:0] burst_to_awlen(input logic [GP_BURST_W-1:0] b);
    logic [GP_BURST_W-1:0] m;
    m = b - GP_BURST_W'(1);
    return (b == '0) ? 8'h00 : 8'(m);
  endfunction

endpackage

// File: rtl/pe2ddr_wr_burst_addr_gen.sv
// Write-address side: latches the descriptor, walks the burst addresses with
// an accumulator, counts issued bursts and throttles on outstanding responses.
module pe2ddr_wr_burst_addr_gen
  import pe2ddr_wr_burst_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_W = GP_BURST_W + 1,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  ddr_burst_desc_t          desc,
  input  logic                     run,
  input  logic                     b_ack,
  input  logic                     awready,
  output logic [GP_DDR_ADDR_W-1:0] awaddr,
  output logic [7:0]               awlen,
  output logic                     awvalid,
  output logic [GP_BURST_W-1:0]    burst_lat,
  output logic [GP_BURST_W-1:0]    burst_num_lat,
  output logic [CNT_W-1:0]         aw_cnt,
  output logic [OUT_W-1:0]         outstanding
);

  logic [GP_DDR_ADDR_W-1:0] addr_reg, addr_next;
  logic [GP_DDR_ADDR_W-1:0] step_reg, step_next;
  logic [GP_BURST_W-1:0]    burst_reg, burst_next;
  logic [GP_BURST_W-1:0]    burst_num_reg, burst_num_next;
  logic [7:0]               awlen_reg, awlen_next;
  logic                     awvalid_reg, awvalid_next;
  logic [CNT_W-1:0]         aw_cnt_reg, aw_cnt_next;
  logic [OUT_W-1:0]         out_reg, out_next;
  logic                     aw_hs;

  // Next-state for descriptor latch, accumulator, counters and awvalid
  always_comb begin
    aw_hs          = awvalid_reg & awready;
    addr_next      = addr_reg;
    step_next      = step_reg;
    burst_next     = burst_reg;
    burst_num_next = burst_num_reg;
    awlen_next     = awlen_reg;
    aw_cnt_next    = aw_cnt_reg + CNT_W'(aw_hs);
    // simultaneous issue and response cancel out
    out_next       = out_reg + OUT_W'(aw_hs) - OUT_W'(b_ack);
    awvalid_next   = 1'b0;
    if (load) begin
      addr_next      = desc.st_addr;
      step_next      = desc.step;
      burst_next     = desc.burst;
      burst_num_next = desc.burst_num;
      awlen_next     = burst_to_awlen(desc.burst);
      aw_cnt_next    = '0;
      out_next       = '0;
      awvalid_next   = (desc.burst != '0) && (desc.burst_num != '0);
    end else begin
      if (aw_hs) begin
        addr_next = addr_reg + step_reg;
      end
      if (awvalid_reg && !awready) begin
        awvalid_next = 1'b1;
      end else if (run) begin
        // registered awvalid looks at next-cycle counts so the limit holds
        awvalid_next = (aw_cnt_next < {1'b0, burst_num_reg}) &&
                       (out_next < OUT_W'(MAX_OUTSTANDING));
      end
    end
  end

  // Address-side state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      step_reg      <= '0;
      burst_reg     <= '0;
      burst_num_reg <= '0;
      awlen_reg     <= '0;
      awvalid_reg   <= 1'b0;
      aw_cnt_reg    <= '0;
      out_reg       <= '0;
    end else begin
      addr_reg      <= addr_next;
      step_reg      <= step_next;
      burst_reg     <= burst_next;
      burst_num_reg <= burst_num_next;
      awlen_reg     <= awlen_next;
      awvalid_reg   <= awvalid_next;
      aw_cnt_reg    <= aw_cnt_next;
      out_reg       <= out_next;
    end
  end

  assign awaddr        = addr_reg;
  assign awlen         = awlen_reg;
  assign awvalid       = awvalid_reg;
  assign burst_lat     = burst_reg;
  assign burst_num_lat = burst_num_reg;
  assign aw_cnt        = aw_cnt_reg;
  assign outstanding   = out_reg;

endmodule

// File: rtl/pe2ddr_wr_burst.sv
// Executes one pe2ddr write descriptor as a series of AXI write bursts and
// pulses done once every burst has been answered.
module pe2ddr_wr_burst
  import pe2ddr_wr_burst_pkg::*;
#(
  parameter int DDR_ADDR_W      = GP_DDR_ADDR_W,
  parameter int BURST_W         = GP_BURST_W,
  parameter int DATA_W          = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DDR_ADDR_W-1:0] st_addr,
  input  logic [BURST_W-1:0]    burst,
  input  logic [DDR_ADDR_W-1:0] step,
  input  logic [BURST_W-1:0]    burst_num,
  output logic                  done,
  output logic                  busy,
  output logic                  err,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DDR_ADDR_W-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wvalid,
  output logic                  wlast,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  localparam int CNT_W = BURST_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  wr_state_e            state_reg, state_next;
  logic [BURST_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [CNT_W-1:0]     w_burst_cnt_reg, w_burst_cnt_next;
  logic [CNT_W-1:0]     b_cnt_reg, b_cnt_next;
  logic                 err_reg, err_next;

  ddr_burst_desc_t      desc_in;
  logic                 accept;
  logic                 run;
  logic [BURST_W-1:0]   burst_lat;
  logic [BURST_W-1:0]   burst_num_lat;
  logic [CNT_W-1:0]     aw_cnt;
  logic [CNT_W-1:0]     aw_cnt_next;
  logic [CNT_W-1:0]     bn_ext;
  logic [OUT_W-1:0]     outstanding;
  logic                 data_ok;
  logic                 beat_last;
  logic                 w_hs;
  logic                 wlast_hs;
  logic                 b_hs;

  assign accept  = start && (state_reg == ST_IDLE);
  assign run     = (state_reg == ST_RUN);
  assign desc_in = '{st_addr: st_addr, burst: burst, step: step, burst_num: burst_num};
  assign bn_ext  = {1'b0, burst_num_lat};

  pe2ddr_wr_burst_addr_gen #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .desc         (desc_in),
    .run          (run),
    .b_ack        (b_hs),
    .awready      (awready),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awvalid      (awvalid),
    .burst_lat    (burst_lat),
    .burst_num_lat(burst_num_lat),
    .aw_cnt       (aw_cnt),
    .outstanding  (outstanding)
  );

  // Data may only flow for bursts whose address has already been accepted
  assign data_ok   = run && (aw_cnt > w_burst_cnt_reg);
  assign beat_last = (beat_cnt_reg == burst_lat - BURST_W'(1));
  assign wdata     = in_data;
  assign wvalid    = in_valid & data_ok;
  assign in_ready  = wready & data_ok;
  assign wlast     = data_ok & beat_last;
  assign w_hs      = wvalid & wready;
  assign wlast_hs  = w_hs & beat_last;

  assign bready    = ((state_reg == ST_RUN) || (state_reg == ST_DRAIN)) && (outstanding != '0);
  assign b_hs      = bvalid & bready;

  assign aw_cnt_next = aw_cnt + CNT_W'(awvalid & awready);

  assign done = (state_reg == ST_DONE);
  assign busy = (state_reg != ST_IDLE);
  assign err  = err_reg;

  // Beat, burst and response counters plus sticky error
  always_comb begin
    beat_cnt_next    = beat_cnt_reg;
    w_burst_cnt_next = w_burst_cnt_reg + CNT_W'(wlast_hs);
    b_cnt_next       = b_cnt_reg + CNT_W'(b_hs);
    err_next         = err_reg | (b_hs && (bresp != AXI_RESP_OKAY));
    if (w_hs) begin
      beat_cnt_next = beat_last ? '0 : beat_cnt_reg + BURST_W'(1);
    end
    if (accept) begin
      beat_cnt_next    = '0;
      w_burst_cnt_next = '0;
      b_cnt_next       = '0;
      err_next         = 1'b0;
    end
  end

  // Transfer FSM; completion is judged on next-cycle counts so done lands
  // exactly one cycle after the final response handshake
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ((burst != '0) && (burst_num != '0)) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if ((aw_cnt_next == bn_ext) && (w_burst_cnt_next == bn_ext)) begin
          state_next = (b_cnt_next == bn_ext) ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (b_cnt_next == bn_ext) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      beat_cnt_reg    <= '0;
      w_burst_cnt_reg <= '0;
      b_cnt_reg       <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      beat_cnt_reg    <= beat_cnt_next;
      w_burst_cnt_reg <= w_burst_cnt_next;
      b_cnt_reg       <= b_cnt_next;
      err_reg         <= err_next;
    end
  end

endmodule

// File: tb/tb_pe2ddr_wr_burst.sv
// Directed, table-driven bench for pe2ddr_wr_burst with a small AXI slave
// and PE-buffer source model.
module tb_pe2ddr_wr_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] st_addr, step;
  logic [7:0]  burst, burst_num;
  logic        done, busy, err;
  logic [63:0] in_data;
  logic        in_valid, in_ready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic        wvalid, wlast, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  pe2ddr_wr_burst dut (
    .clk(clk), .rst(rst), .start(start), .st_addr(st_addr), .burst(burst),
    .step(step), .burst_num(burst_num), .done(done), .busy(busy), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] st;
    int          burst;
    logic [31:0] step;
    int          bn;
    bit          stall;
    int          err_idx;
    int          exp_beats;
    bit          exp_err;
    logic [31:0] exp_last_addr;
  } vec_t;

  vec_t vecs[5];

  int n_checks = 0;
  int n_fail   = 0;

  // model / scoreboard state
  logic [31:0] m_st, m_step;
  int  m_burst, m_bn, err_idx;
  bit  stall, b_en;
  int  aw_seen, w_beats, w_bursts, b_seen, pending_b;
  int  cyc, last_b_cyc, done_cyc, done_cnt;
  logic [31:0] first_awaddr, last_awaddr;
  bit  seen_aw, seen_w;
  // previous-cycle stall snapshot
  bit  p_aw_stall, p_w_stall, p_in_hold, p_b_hold;
  logic [31:0] p_awaddr;
  logic [7:0]  p_awlen;
  logic        p_wlast;
  logic [63:0] p_wdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    aw_seen = 0; w_beats = 0; w_bursts = 0; b_seen = 0; pending_b = 0;
    done_cnt = 0; last_b_cyc = -1; done_cyc = -1;
    seen_aw = 0; seen_w = 0; first_awaddr = '0; last_awaddr = '0;
  endtask

  // One clock: drive slave/source, observe handshakes, advance to next negedge
  task automatic cycle();
    logic aw_hs, w_hs, b_hs;
    logic [31:0] exp_a;
    if (!p_in_hold) begin
      in_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = {$urandom, $urandom};
    end
    awready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    wready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!p_b_hold)
      bvalid = b_en && (pending_b > 0) && (!stall || ($urandom_range(0, 1) == 1));
    bresp = (b_seen == err_idx) ? 2'b10 : 2'b00;
    #1;
    if (!rst) begin
      if (p_aw_stall) begin
        chk("aw_hold_valid", awvalid, 1);
        chk("aw_hold_addr", awaddr, p_awaddr);
        chk("aw_hold_len", awlen, p_awlen);
      end
      if (p_w_stall) begin
        chk("w_hold_valid", wvalid, 1);
        chk("w_hold_last", wlast, p_wlast);
        chk("w_hold_data", wdata, p_wdata);
      end
    end
    aw_hs = awvalid & awready;
    w_hs  = wvalid & wready;
    b_hs  = bvalid & bready;
    if (w_hs) begin
      chk("w_after_aw", (w_bursts < aw_seen), 1);
      chk("wlast", wlast, (m_burst > 0) && ((w_beats % m_burst) == m_burst - 1));
      chk("wdata", wdata, in_data);
      w_beats++;
      if (wlast) begin
        w_bursts++;
        pending_b++;
      end
    end
    if (aw_hs) begin
      exp_a = m_st + 32'(aw_seen) * m_step;
      chk("awaddr", awaddr, exp_a);
      chk("awlen", awlen, 8'(m_burst - 1));
      if (aw_seen == 0) first_awaddr = awaddr;
      last_awaddr = awaddr;
      aw_seen++;
    end
    if (b_hs) begin
      b_seen++;
      pending_b--;
      last_b_cyc = cyc;
    end
    if (awvalid) seen_aw = 1;
    if (wvalid)  seen_w  = 1;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    p_aw_stall = awvalid & ~awready;
    p_awaddr   = awaddr;
    p_awlen    = awlen;
    p_w_stall  = wvalid & ~wready;
    p_wlast    = wlast;
    p_wdata    = wdata;
    p_in_hold  = in_valid & ~in_ready;
    p_b_hold   = bvalid & ~bready;
    if (rst) begin
      p_aw_stall = 0; p_w_stall = 0; p_in_hold = 0; p_b_hold = 0; pending_b = 0;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_awaddr"}, awaddr, 0);
    chk({tag, "_awlen"}, awlen, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_wlast"}, wlast, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_bready"}, bready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic start_xfer(input vec_t v);
    m_st = v.st; m_step = v.step; m_burst = v.burst; m_bn = v.bn;
    stall = v.stall; err_idx = v.err_idx;
    model_clear();
    st_addr = v.st; step = v.step; burst = 8'(v.burst); burst_num = 8'(v.bn);
    start = 1'b1;
    cycle();
    start = 1'b0;
    st_addr = 32'hDEAD_BEEF; step = 32'h0BAD_0BAD; burst = 8'hEE; burst_num = 8'hEE;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    start_xfer(v);
    chk({tag, "_busy_after_start"}, busy, 1);
    chk({tag, "_err_cleared"}, err, 0);
    wait_done(4000);
    chk({tag, "_done_seen"}, done_cnt, 1);
    chk({tag, "_beats"}, w_beats, v.exp_beats);
    chk({tag, "_aw_count"}, aw_seen, v.bn);
    chk({tag, "_b_count"}, b_seen, v.bn);
    chk({tag, "_last_awaddr"}, last_awaddr, v.exp_last_addr);
    chk({tag, "_done_latency"}, done_cyc, last_b_cyc + 1);
    chk({tag, "_err"}, err, v.exp_err);
    cycle();
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_single_done"}, done_cnt, 1);
    $display("xfer %s: st=0x%0h burst=%0d bn=%0d beats=%0d bursts=%0d resp=%0d err=%0b",
             tag, v.st, v.burst, v.bn, w_beats, aw_seen, b_seen, err);
  endtask

  initial begin
    vec_t z;
    vecs[0] = '{32'h0000_1000, 4, 32'h200, 3, 1'b0, -1, 12, 1'b0, 32'h0000_1400};
    vecs[1] = '{32'h0000_2000, 5, 32'h100, 6, 1'b1, -1, 30, 1'b0, 32'h0000_2500};
    vecs[2] = '{32'h0000_3000, 3, 32'h040, 3, 1'b0,  1,  9, 1'b1, 32'h0000_3080};
    vecs[3] = '{32'h0000_4000, 1, 32'h010, 4, 1'b1, -1,  4, 1'b0, 32'h0000_4030};
    vecs[4] = '{32'hFFFF_FF00, 2, 32'h080, 3, 1'b0, -1,  6, 1'b0, 32'h0000_0000};

    cyc = 0; stall = 0; b_en = 1; err_idx = -1; m_burst = 1; m_st = 0; m_step = 0;
    p_aw_stall = 0; p_w_stall = 0; p_in_hold = 0; p_b_hold = 0;
    model_clear();
    rst = 1'b1; start = 1'b0; st_addr = '0; step = '0; burst = '0; burst_num = '0;
    in_data = '0; in_valid = 1'b0; awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    repeat (3) cycle();
    chk_outputs_zero("reset");
    rst = 1'b0;
    cycle();

    // table-driven transfers
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // zero-length descriptors: no traffic, one busy/done cycle
    for (int k = 0; k < 2; k++) begin
      z = '{32'h0000_9000, (k == 0) ? 0 : 4, 32'h100, (k == 0) ? 5 : 0, 1'b0, -1, 0, 1'b0, 32'h0};
      start_xfer(z);
      chk("zero_busy", busy, 1);
      chk("zero_done", done, 1);
      cycle();
      chk("zero_busy_off", busy, 0);
      chk("zero_done_off", done, 0);
      repeat (3) cycle();
      chk("zero_no_awvalid", seen_aw, 0);
      chk("zero_no_wvalid", seen_w, 0);
      chk("zero_single_done", done_cnt, 1);
      $display("xfer zero%0d: burst=%0d bn=%0d done_pulses=%0d", k, z.burst, z.bn, done_cnt);
    end

    // outstanding limit: responses withheld
    b_en = 1'b0;
    z = '{32'h0000_5000, 2, 32'h20, 8, 1'b0, -1, 16, 1'b0, 32'h0000_50E0};
    start_xfer(z);
    repeat (40) cycle();
    chk("limit_aw_count", aw_seen, 4);
    chk("limit_awvalid_low", awvalid, 0);
    chk("limit_no_done", done_cnt, 0);
    b_en = 1'b1;
    wait_done(1000);
    chk("limit_done_seen", done_cnt, 1);
    chk("limit_aw_total", aw_seen, 8);
    chk("limit_b_total", b_seen, 8);
    chk("limit_last_addr", last_awaddr, z.exp_last_addr);
    chk("limit_done_latency", done_cyc, last_b_cyc + 1);
    cycle();
    $display("xfer limit: bursts=%0d beats=%0d resp=%0d", aw_seen, w_beats, b_seen);

    // reset mid-transfer, then a fresh descriptor
    z = '{32'h0000_6000, 4, 32'h100, 6, 1'b0, -1, 24, 1'b0, 32'h0000_6500};
    start_xfer(z);
    for (int i = 0; i < 200 && w_bursts < 2; i++) cycle();
    chk("midrst_reached", w_bursts, 2);
    rst = 1'b1;
    done_cnt = 0;
    cycle();
    chk_outputs_zero("midrst");
    cycle();
    chk_outputs_zero("midrst2");
    rst = 1'b0;
    repeat (6) cycle();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", busy, 0);
    $display("xfer abort: reset after %0d bursts, done_pulses=%0d", 2, done_cnt);
    z = '{32'h0000_8000, 2, 32'h40, 3, 1'b0, -1, 6, 1'b0, 32'h0000_8080};
    run_vec(z, "after_rst");
    chk("after_rst_first_addr", first_awaddr, 32'h0000_8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
